// File: rtl/shift_pkg.sv
// Shared types and defaults for the shift-register serial link blocks.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        FULL = 2'd2
    } deser_state_t;

    localparam int unsigned DEFAULT_WIDTH = 16;

endpackage

// File: rtl/bit_counter.sv
// Saturating up-counter of accepted serial bits with a terminal flag one short of a full word.
module bit_counter #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && count_q != CNT_W'(WIDTH)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;
    assign last  = (count_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/shift_deserializer16.sv
// MSB-first serial-to-parallel receiver: frames WIDTH bits into a word offered on valid/ready.
module shift_deserializer16
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sin,
    input  logic             sin_valid,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             busy,
    output logic [CNT_W-1:0] bit_count,
    output logic             overrun
);

    deser_state_t     state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             cnt_clr, cnt_inc, cnt_last;

    bit_counter #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_bit_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .count(bit_count),
        .last (cnt_last)
    );

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RECV;
                    word_d    = '0;
                    overrun_d = 1'b0;
                    cnt_clr   = 1'b1;
                end
            end
            RECV: begin
                // A restart discards any bit presented in the same cycle.
                if (start) begin
                    word_d  = '0;
                    cnt_clr = 1'b1;
                end else if (sin_valid) begin
                    word_d  = {word_q[WIDTH-2:0], sin};
                    cnt_inc = 1'b1;
                    if (cnt_last) begin
                        state_d = FULL;
                        valid_d = 1'b1;
                    end
                end
            end
            FULL: begin
                if (sin_valid && !(valid_q && word_ready && start)) begin
                    overrun_d = 1'b1;
                end
                if (valid_q && word_ready) begin
                    valid_d = 1'b0;
                    cnt_clr = 1'b1;
                    if (start) begin
                        state_d   = RECV;
                        word_d    = '0;
                        overrun_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            word_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign busy       = (state_q == RECV);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_shift_deserializer16.sv
// Scoreboard bench for shift_deserializer16: expected words queued at send, popped on handshake.
module tb_shift_deserializer16;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             sin = 1'b0;
    logic             sin_valid = 1'b0;
    logic             word_ready = 1'b0;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             busy;
    logic [CNT_W-1:0] bit_count;
    logic             overrun;

    int n_checks = 0;
    int n_fail = 0;
    logic [WIDTH-1:0] exp_q[$];

    shift_deserializer16 #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sin       (sin),
        .sin_valid (sin_valid),
        .word_out  (word_out),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .busy      (busy),
        .bit_count (bit_count),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Handshake monitor: word_ready/word_valid here are what the next edge samples.
    always @(negedge clk) begin
        if (rst && word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                check("sb_word", 32'(word_out), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        sin       = b;
        sin_valid = 1'b1;
        tick();
        sin_valid = 1'b0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input bit gaps);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (gaps) begin
                int n;
                n = $urandom_range(1, 3);
                for (int g = 0; g < n; g++) begin
                    tick();
                    check("gap_count", 32'(bit_count), 32'(WIDTH - 1 - i));
                end
            end
            send_bit(w[i]);
            if (gaps) check("bit_count", 32'(bit_count), 32'(WIDTH - i));
        end
    endtask

    task automatic accept();
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (3) tick();
        check("rst_word", 32'(word_out), 32'd0);
        check("rst_valid", 32'(word_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(bit_count), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b1;
        tick();

        // Continuous stream
        start_frame();
        check("t1_busy", 32'(busy), 32'd1);
        exp_q.push_back(16'hA5C3);
        send_word(16'hA5C3, 1'b0);
        check("t1_word", 32'(word_out), 32'h0000A5C3);
        check("t1_valid", 32'(word_valid), 32'd1);
        check("t1_busy_full", 32'(busy), 32'd0);
        check("t1_count", 32'(bit_count), 32'd16);
        accept();
        check("t1_valid_drop", 32'(word_valid), 32'd0);
        check("t1_count_clr", 32'(bit_count), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);

        // Gapped stream
        start_frame();
        exp_q.push_back(16'h8001);
        send_word(16'h8001, 1'b1);
        check("t2_word", 32'(word_out), 32'h00008001);
        check("t2_valid", 32'(word_valid), 32'd1);
        accept();

        // Backpressure and overrun
        start_frame();
        exp_q.push_back(16'h1234);
        send_word(16'h1234, 1'b0);
        for (int c = 0; c < 5; c++) begin
            sin_valid = (c == 2);
            sin       = 1'b1;
            tick();
            sin_valid = 1'b0;
            check("t3_hold_word", 32'(word_out), 32'h00001234);
            check("t3_hold_valid", 32'(word_valid), 32'd1);
        end
        check("t3_overrun", 32'(overrun), 32'd1);
        start_frame();
        check("t3_start_ignored", 32'(word_valid), 32'd1);
        check("t3_start_busy", 32'(busy), 32'd0);
        accept();
        check("t3_valid_drop", 32'(word_valid), 32'd0);
        check("t3_idle", 32'(busy), 32'd0);
        check("t3_sticky", 32'(overrun), 32'd1);
        start_frame();
        check("t3_ovr_clr", 32'(overrun), 32'd0);
        check("t3_busy", 32'(busy), 32'd1);

        // Restart mid-frame
        start_frame();
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        check("t4_partial", 32'(bit_count), 32'd7);
        start_frame();
        check("t4_restart", 32'(bit_count), 32'd0);
        exp_q.push_back(16'h00FF);
        send_word(16'h00FF, 1'b0);
        check("t4_word", 32'(word_out), 32'h000000FF);
        check("t4_count", 32'(bit_count), 32'd16);
        accept();

        // Back-to-back frames
        start_frame();
        exp_q.push_back(16'hFFFF);
        send_word(16'hFFFF, 1'b0);
        word_ready = 1'b1;
        start      = 1'b1;
        tick();
        word_ready = 1'b0;
        start      = 1'b0;
        check("t5_valid_drop", 32'(word_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd1);
        check("t5_count", 32'(bit_count), 32'd0);
        exp_q.push_back(16'h0000);
        for (int i = 0; i < 15; i++) send_bit(1'b0);
        check("t5_not_early", 32'(word_valid), 32'd0);
        send_bit(1'b0);
        check("t5_valid", 32'(word_valid), 32'd1);
        check("t5_word", 32'(word_out), 32'd0);
        accept();

        // Asynchronous reset mid-frame
        start_frame();
        for (int i = 0; i < 9; i++) send_bit(i[0]);
        check("t6_partial", 32'(bit_count), 32'd9);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("t6_rst_count", 32'(bit_count), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_word", 32'(word_out), 32'd0);
        check("t6_rst_valid", 32'(word_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        check("t6_idle_count", 32'(bit_count), 32'd0);
        check("t6_idle_busy", 32'(busy), 32'd0);
        check("t6_idle_overrun", 32'(overrun), 32'd0);
        check("t6_idle_valid", 32'(word_valid), 32'd0);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_deserializer16.md
# shift_deserializer16

Serial-to-parallel receiver for the left-shift (MSB-first) serial streams produced by the 16-bit shift registers in the datapath. It collects a framed run of serial bits into a WIDTH-bit word and presents it on a valid/ready handshake to the consumer. It flags bits that arrive while an unread word is held. It sits at the receiving end of any left-shifting serializer link and feeds a register or FSM that loads whole words.

## Interface
- WIDTH, 16, word length in bits; the minimum legal value is 2.
- CNT_W, $clog2(WIDTH+1), width of the bit counter.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- start  in  1  begin a new word: clears the shift register and the bit count.
- sin  in  1  serial data bit, MSB first.
- sin_valid  in  1  sin is sampled on this edge.
- word_out  out  WIDTH  shift-register contents; meaningful only while word_valid=1.
- word_valid  out  1  a complete word is held.
- word_ready  in  1  the consumer accepts the word.
- busy  out  1  a word is being received (state RECV).
- bit_count  out  CNT_W  number of bits accepted in the current word.
- overrun  out  1  sticky: a bit was dropped while in FULL; cleared by start.

## Operation
- Reset values while rst=0: state IDLE, word_out=0, word_valid=0, busy=0, bit_count=0, overrun=0.
- IDLE:
  - sin_valid is ignored and does not set overrun.
  - start=1 → RECV; word_out←0; bit_count←0; overrun←0.
- RECV:
  - When sin_valid=1, word_out←{word_out[WIDTH-2:0], sin} and bit_count←bit_count+1.
  - When sin_valid=1 and bit_count=WIDTH-1, the word completes: → FULL, word_valid←1, bit_count←WIDTH.
  - start=1 restarts the frame: word_out←0, bit_count←0, and the state stays RECV. start takes priority over a simultaneous sin_valid, so that bit is discarded.
- FULL:
  - word_out is frozen.
  - If word_valid=1 and word_ready=1, the handshake completes: word_valid←0 and bit_count←0. The next state is RECV if start=1 in the same cycle (word_out←0, overrun←0); otherwise it is IDLE.
  - sin_valid=1 sets overrun←1 and the bit is dropped. This happens even on the handshake cycle, unless start is also 1.
  - start=1 without word_ready is ignored.
- The FSM has three states: IDLE, RECV, FULL. Encodings 2'd0, 2'd1, 2'd2. The unused encoding 2'd3 goes to IDLE on the next edge.
- bit_count never exceeds WIDTH and never wraps.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- word_valid rises on the same edge that samples the WIDTH-th accepted bit. It is visible in the following cycle.
- word_valid stays high until a cycle in which word_ready=1. It falls on that edge.
- Minimum frame: 1 start cycle + WIDTH bit cycles + 1 handshake cycle. Starting the next frame alongside the handshake gives back-to-back frames with no idle cycle.
- Gaps in sin_valid stall the frame indefinitely. There is no timeout.
- Reset mid-frame takes effect immediately and asynchronously. The partial word is lost and all outputs take their reset values.

## Structure
- Shared package shift_pkg holds:
  - typedef deser_state_t {IDLE, RECV, FULL};
  - localparam DEFAULT_WIDTH=16.
- One natural sub-module: bit_counter. It is a CNT_W-bit up-counter with clr, inc and a terminal flag at WIDTH-1.
- The shift register and the FSM stay in the top module.

## Test plan
- Reset, start, then 16 bits of 0xA5C3 MSB-first with sin_valid held high → word_out=16'hA5C3 and word_valid=1 in the cycle after the 16th bit; busy=0; bit_count=16.
- The same word 0x8001 with random 1–3 cycle sin_valid gaps → word_out=16'h8001; bit_count increments only on sin_valid cycles.
- Backpressure: complete 0x1234 with word_ready=0 for 5 cycles and pulse sin_valid during the hold → word_out stays 16'h1234 and overrun=1. Then word_ready=1 → word_valid=0 and the FSM returns to IDLE. Then start → overrun=0.
- Restart: start, 7 bits of 1, start again, then 16 bits of 0x00FF → word_out=16'h00FF and bit_count=16; no stale bits remain.
- Back-to-back: in FULL holding 0xFFFF, assert word_ready and start together, then 16 bits of 0x0000 → the second word_valid rises exactly 16 sin_valid cycles later with word_out=16'h0000.
- Async reset: drive rst=0 mid-frame after 9 bits, between clock edges → outputs go to reset values immediately; after release, sin_valid without start is ignored (bit_count stays 0).
